// File: rtl/custom_subtractor56_19_seq.sv
// 56-bit minus zero-extended 37-bit subtractor, one 8-bit slice per cycle with a registered borrow.
// Optional macro CUSTOM_SUB56_SATURATE_EN clamps a borrowing result to zero on entry to DONE.
module custom_subtractor56_19_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] A,
  input  logic [36:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [55:0] Diff,
  output logic        Borrow,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  logic [55:0] r_opA;
  logic [55:0] r_opB;
  logic [55:0] r_diff;
  logic        r_borrow;
  logic [2:0]  r_k;
  logic        r_in_ready;
  logic        r_out_valid;

  logic [5:0]  w_base;
  logic [8:0]  w_slice;

  // Bit offset of the slice handled this cycle; bit 8 of w_slice is the borrow out.
  assign w_base  = {r_k, 3'b000};
  assign w_slice = {1'b0, r_opA[w_base +: 8]} - {1'b0, r_opB[w_base +: 8]} - {8'b0, r_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_opA       <= '0;
      r_opB       <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_opA      <= A;
            r_opB      <= {19'b0, B};
            r_borrow   <= 1'b0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_diff[w_base +: 8] <= w_slice[7:0];
          r_borrow            <= w_slice[8];
          r_k                 <= r_k + 3'd1;
          if (r_k == 3'd6) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
`ifdef CUSTOM_SUB56_SATURATE_EN
            if (w_slice[8]) r_diff <= '0;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Diff      = r_diff;
  assign Borrow    = r_borrow;

endmodule

// File: tb/tb_custom_subtractor56_19_seq.sv
// Self-checking bench for custom_subtractor56_19_seq: directed corners, random operands, backpressure, reset.
module tb_custom_subtractor56_19_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] A;
  logic [36:0] B;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] Diff;
  logic        Borrow;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  custom_subtractor56_19_seq dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
    .Diff(Diff), .Borrow(Borrow), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Reference: plain wide arithmetic on the whole operands.
  function automatic logic [56:0] ref_sub(input logic [55:0] a, input logic [36:0] b);
    logic [56:0] wide;
    logic        bo;
    wide = {1'b0, a} - {20'b0, b};
    bo   = (a < {19'b0, b});
`ifdef CUSTOM_SUB56_SATURATE_EN
    if (bo) wide = '0;
`endif
    return {bo, wide[55:0]};
  endfunction

  function automatic logic [55:0] rand56();
    return {$urandom_range(16777215, 0), $urandom()};
  endfunction

  // Issue one operation, wait for the result, record it and the accept-to-valid latency.
  task automatic run_op(input logic [55:0] a, input logic [36:0] b,
                        output logic [55:0] d, output logic bo, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 30) begin @(negedge clk); w++; end
    A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    d = Diff; bo = Borrow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [55:0] a, input logic [36:0] b);
    logic [55:0] d;
    logic        bo;
    logic [56:0] exp;
    int          lat;
    run_op(a, b, d, bo, lat);
    exp = ref_sub(a, b);
    n_cmp++;
    if ({bo, d} !== exp) begin
      n_bad++;
      $display("FAIL %s: got Borrow=%0b Diff=%h, want Borrow=%0b Diff=%h", name, bo, d, exp[56], exp[55:0]);
    end
    n_cmp++;
    if (lat !== 7) begin
      n_bad++;
      $display("FAIL %s latency: got %0d, want 7", name, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; A = '0; B = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, Borrow, Diff} !== 59'd0) begin
      n_bad++;
      $display("FAIL reset_state: got in_ready=%0b out_valid=%0b Borrow=%0b Diff=%h, want all 0",
               in_ready, out_valid, Borrow, Diff);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_in_ready: got %0b, want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [55:0] d;
    logic        bo;
    int          lat;
    check_op("all_ones_minus_1", 56'hFF_FFFF_FFFF_FFFF, 37'd1);
    check_op("slice_boundary",   56'h100, 37'd1);
    check_op("ripple_6_slices",  56'h1_0000_0000_0000, 37'd1);
    check_op("equal_operands",   56'h1F_FFFF_FFFF, 37'h1F_FFFF_FFFF);
    check_op("zero_minus_zero",  56'd0, 37'd0);
    // Wrap-around corner also checked against a literal value.
    run_op(56'd0, 37'h1F_FFFF_FFFF, d, bo, lat);
    n_cmp++;
`ifdef CUSTOM_SUB56_SATURATE_EN
    if ({bo, d} !== {1'b1, 56'd0}) begin
`else
    if ({bo, d} !== {1'b1, 56'hFF_FFE0_0000_0001}) begin
`endif
      n_bad++;
      $display("FAIL wrap_literal: got Borrow=%0b Diff=%h", bo, d);
    end
  endtask

  task automatic test_random();
    logic [55:0] a;
    logic [36:0] b;
    for (int i = 0; i < 40; i++) begin
      a = rand56();
      b = {$urandom_range(31, 0), $urandom()};
      if (i % 4 == 0) a = a >> $urandom_range(55, 20);
      check_op("random", a, b);
    end
  endtask

  task automatic test_backpressure();
    logic [55:0] d0;
    logic        b0;
    logic [55:0] na;
    logic [36:0] nb;
    logic [56:0] exp;
    int          w;
    exp = ref_sub(56'h12_3456_789A_BCDE, 37'h15_5555_5555);
    @(negedge clk);
    A = 56'h12_3456_789A_BCDE; B = 37'h15_5555_5555; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 30) begin @(negedge clk); w++; end
    d0 = Diff; b0 = Borrow;
    n_cmp++;
    if ({b0, d0} !== exp) begin
      n_bad++;
      $display("FAIL bp_result: got Borrow=%0b Diff=%h, want Borrow=%0b Diff=%h", b0, d0, exp[56], exp[55:0]);
    end
    na = rand56(); nb = {$urandom_range(31, 0), $urandom()};
    for (int c = 0; c < 5; c++) begin
      A = na; B = nb; in_valid = c[0];
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, Borrow, Diff} !== {1'b1, 1'b0, b0, d0}) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: got out_valid=%0b in_ready=%0b Borrow=%0b Diff=%h, want 1 0 %0b %h",
                 c, out_valid, in_ready, Borrow, Diff, b0, d0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, Borrow, Diff} !== {1'b0, 1'b1, b0, d0}) begin
      n_bad++;
      $display("FAIL bp_release: got out_valid=%0b in_ready=%0b Diff=%h, want 0 1 %h", out_valid, in_ready, Diff, d0);
    end
    check_op("bp_next_op", na, nb);
  endtask

  task automatic test_back_to_back();
    logic [56:0] e1, e2;
    logic [55:0] a2;
    logic [36:0] b2;
    int          w;
    a2 = rand56(); b2 = {$urandom_range(31, 0), $urandom()};
    e1 = ref_sub(56'h80_0000_0000_0000, 37'h10_0000_0001);
    e2 = ref_sub(a2, b2);
    @(negedge clk);
    A = 56'h80_0000_0000_0000; B = 37'h10_0000_0001; in_valid = 1'b1;
    @(negedge clk);
    A = a2; B = b2;
    w = 0;
    while (!out_valid && w < 30) begin @(negedge clk); w++; end
    n_cmp++;
    if ({Borrow, Diff} !== e1) begin
      n_bad++;
      $display("FAIL b2b_first: got Borrow=%0b Diff=%h, want Borrow=%0b Diff=%h", Borrow, Diff, e1[56], e1[55:0]);
    end
    out_ready = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_no_accept_in_handshake: in_ready got %0b, want 0", in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_idle_visit: got out_valid=%0b in_ready=%0b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 30) begin @(negedge clk); w++; end
    n_cmp++;
    if ({Borrow, Diff} !== e2 || w !== 7) begin
      n_bad++;
      $display("FAIL b2b_second: got Borrow=%0b Diff=%h lat=%0d, want Borrow=%0b Diff=%h lat=7",
               Borrow, Diff, w, e2[56], e2[55:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    @(negedge clk);
    A = 56'hFF_FFFF_FFFF_FFFF; B = 37'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, Borrow, Diff} !== 59'd0) begin
      n_bad++;
      $display("FAIL reset_mid_async: got out_valid=%0b in_ready=%0b Borrow=%0b Diff=%h, want all 0",
               out_valid, in_ready, Borrow, Diff);
    end
    seen_valid = 1'b0;
    repeat (2) begin @(negedge clk); seen_valid |= out_valid; end
    rst = 1'b0;
    @(negedge clk);
    seen_valid |= out_valid;
    n_cmp++;
    if ({seen_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_mid_release: got out_valid_seen=%0b in_ready=%0b, want 0 1", seen_valid, in_ready);
    end
    check_op("after_reset_1000_minus_1", 56'd1000, 37'd1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
